// File: rtl/vga_char_scan.sv
// VGA raster walker and pixel stage for a tile-indexed character buffer: drives the read
// address, samples lit/out_of_bounds, and registers RGB with aligned syncs. Macro: VGA_BORDER_EN.
module vga_char_scan #(
    parameter int unsigned p_clk_div    = 2,
    parameter int unsigned p_h_active   = 640,
    parameter int unsigned p_h_fp       = 16,
    parameter int unsigned p_h_sync     = 96,
    parameter int unsigned p_h_bp       = 48,
    parameter int unsigned p_v_active   = 480,
    parameter int unsigned p_v_fp       = 10,
    parameter int unsigned p_v_sync     = 2,
    parameter int unsigned p_v_bp       = 33,
    parameter logic [11:0] p_fg_rgb     = 12'hFFF,
    parameter logic [11:0] p_bg_rgb     = 12'h000,
    parameter logic [11:0] p_border_rgb = 12'h00F
) (
    input  logic        clk,
    input  logic        rst,
    output logic [6:0]  read_hchar,
    output logic [4:0]  read_vchar,
    output logic [2:0]  read_hoffset,
    output logic [3:0]  read_voffset,
    input  logic        read_lit,
    input  logic        out_of_bounds,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [11:0] vga_rgb,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = p_h_active + p_h_fp + p_h_sync + p_h_bp;
    localparam int unsigned V_TOTAL = p_v_active + p_v_fp + p_v_sync + p_v_bp;
    localparam int unsigned DIV_W   = $clog2(p_clk_div);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(p_clk_div - 1);
    localparam logic [9:0]       H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT      = 10'(p_h_active);
    localparam logic [9:0]       V_ACT      = 10'(p_v_active);
    localparam logic [9:0]       H_SYNC_BEG = 10'(p_h_active + p_h_fp);
    localparam logic [9:0]       H_SYNC_END = 10'(p_h_active + p_h_fp + p_h_sync);
    localparam logic [9:0]       V_SYNC_BEG = 10'(p_v_active + p_v_fp);
    localparam logic [9:0]       V_SYNC_END = 10'(p_v_active + p_v_fp + p_v_sync);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             pix_stb;
    logic             active;
    logic             oob_sel;

    logic [11:0]      rgb_p1_q, rgb_p1_d;
    logic             hsync_p1_q, hsync_p1_d;
    logic             vsync_p1_q, vsync_p1_d;
    logic             vld_p1_q, vld_p1_d;
    logic             frame_start_q, frame_start_d;

`ifdef VGA_BORDER_EN
    assign oob_sel = out_of_bounds;
`else
    logic unused_oob;
    assign unused_oob = out_of_bounds;
    assign oob_sel    = 1'b0;
`endif

    // Blanking wins over everything; out-of-bounds only reaches here with the border enabled.
    function automatic logic [11:0] pix_colour(input logic act, input logic lit, input logic oob);
        logic [11:0] c;
        if (!act)     c = 12'h000;
        else if (oob) c = p_border_rgb;
        else if (lit) c = p_fg_rgb;
        else          c = p_bg_rgb;
        return c;
    endfunction

    assign pix_stb = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = pix_stb ? '0 : div_cnt_q + DIV_W'(1);
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        if (pix_stb) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Stage 1: read_lit has had p_clk_div-1 clks to settle against the current address.
    always_comb begin
        active        = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        rgb_p1_d      = rgb_p1_q;
        hsync_p1_d    = hsync_p1_q;
        vsync_p1_d    = vsync_p1_q;
        vld_p1_d      = vld_p1_q;
        frame_start_d = 1'b0;
        if (pix_stb) begin
            rgb_p1_d      = pix_colour(active, read_lit, oob_sel);
            hsync_p1_d    = !((hcount_q >= H_SYNC_BEG) && (hcount_q < H_SYNC_END));
            vsync_p1_d    = !((vcount_q >= V_SYNC_BEG) && (vcount_q < V_SYNC_END));
            vld_p1_d      = 1'b1;
            frame_start_d = vld_p1_q && (hcount_q == 10'd0) && (vcount_q == 10'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            rgb_p1_q      <= '0;
            hsync_p1_q    <= 1'b1;
            vsync_p1_q    <= 1'b1;
            vld_p1_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            rgb_p1_q      <= rgb_p1_d;
            hsync_p1_q    <= hsync_p1_d;
            vsync_p1_q    <= vsync_p1_d;
            vld_p1_q      <= vld_p1_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign read_hchar   = hcount_q[9:3];
    assign read_hoffset = hcount_q[2:0];
    assign read_vchar   = vcount_q[8:4];
    assign read_voffset = vcount_q[3:0];
    assign vga_rgb      = rgb_p1_q;
    assign vga_hsync    = hsync_p1_q;
    assign vga_vsync    = vsync_p1_q;
    assign frame_start  = frame_start_q;

endmodule
